// File: rtl/or_delta.sv
// Or-opt move cost evaluator: fetches five tour positions and six edge lengths,
// then reports the signed tour-length change of moving city K to just after L.
package replica_pkg;
  localparam int city_num = 8;
  localparam int city_w   = $clog2(city_num);

  typedef enum logic {THR = 1'b0, OR1 = 1'b1} com_t;

  typedef struct packed {
    com_t              com;
    logic [3:0]        base_id;
    logic [city_w-1:0] K;
    logic [city_w-1:0] L;
    logic [15:0]       r_metropolis;
  } opt_t;
endpackage

module or_delta
  import replica_pkg::*;
#(
  parameter int DIST_W   = 16,
  parameter int CITY_NUM = city_num,
  parameter int CITY_W   = $clog2(CITY_NUM)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run_i,
  input  opt_t                       opt_i,
  output logic [CITY_W-1:0]          ord_addr,
  input  logic [CITY_W-1:0]          ord_data,
  output logic [2*CITY_W-1:0]        dist_addr,
  input  logic [DIST_W-1:0]          dist_data,
  output logic                       run_o,
  output opt_t                       opt_o,
  output logic signed [DIST_W+2:0]   delta,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, RD_ORD, RD_DIST, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [2:0]                 cnt_reg;
  opt_t                       opt_reg;
  logic signed [DIST_W+2:0]   delta_reg;
  logic [CITY_W-1:0]          ord_addr_reg;
  logic [2*CITY_W-1:0]        dist_addr_reg;
  logic [5*CITY_W-1:0]        city_vec;
  logic [CITY_W-1:0]          ord_next;
  logic [2*CITY_W-1:0]        edge_next;
  logic [CITY_W-1:0]          c0, c1, c2, c3, c4;
  logic signed [DIST_W+2:0]   dist_ext;

  function automatic logic [CITY_W-1:0] pos_inc(input logic [CITY_W-1:0] p);
    return (p == CITY_W'(CITY_NUM - 1)) ? '0 : p + CITY_W'(1);
  endfunction

  function automatic logic [CITY_W-1:0] pos_dec(input logic [CITY_W-1:0] p);
    return (p == '0) ? CITY_W'(CITY_NUM - 1) : p - CITY_W'(1);
  endfunction

  // Tour position i's city id is captured in RD_ORD count i+1 (one-cycle RAM latency).
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_city
      logic [CITY_W-1:0] city_reg;
      always_ff @(posedge clk) begin
        if (state_reg == RD_ORD && cnt_reg == 3'(gi + 1))
          city_reg <= ord_data;
      end
      assign city_vec[gi*CITY_W +: CITY_W] = city_reg;
    end
  endgenerate

  assign c0 = city_vec[0*CITY_W +: CITY_W];
  assign c1 = city_vec[1*CITY_W +: CITY_W];
  assign c2 = city_vec[2*CITY_W +: CITY_W];
  assign c3 = city_vec[3*CITY_W +: CITY_W];
  assign c4 = city_vec[4*CITY_W +: CITY_W];

  assign dist_ext = $signed({3'b000, dist_data});

  always_comb begin
    ord_next = CITY_W'(opt_reg.K);
    case (cnt_reg)
      3'd0:    ord_next = CITY_W'(opt_reg.K);
      3'd1:    ord_next = pos_inc(CITY_W'(opt_reg.K));
      3'd2:    ord_next = CITY_W'(opt_reg.L);
      default: ord_next = pos_inc(CITY_W'(opt_reg.L));
    endcase
  end

  // Edge 1 is issued on leaving RD_ORD; edges 2..6 follow one per RD_DIST count.
  always_comb begin
    edge_next = {c1, c4};
    case (cnt_reg)
      3'd0:    edge_next = {c1, c2};
      3'd1:    edge_next = {c3, c4};
      3'd2:    edge_next = {c0, c2};
      3'd3:    edge_next = {c3, c1};
      default: edge_next = {c1, c4};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    run_o      = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (run_i) state_next = (opt_i.com == OR1) ? RD_ORD : DONE;
      end
      RD_ORD:  if (cnt_reg == 3'd5) state_next = RD_DIST;
      RD_DIST: if (cnt_reg == 3'd6) state_next = DONE;
      default: begin
        run_o      = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      opt_reg       <= '0;
      delta_reg     <= '0;
      ord_addr_reg  <= '0;
      dist_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (run_i) begin
            opt_reg   <= opt_i;
            delta_reg <= '0;
            if (opt_i.com == OR1) ord_addr_reg <= pos_dec(CITY_W'(opt_i.K));
          end
        end
        RD_ORD: begin
          cnt_reg <= (cnt_reg == 3'd5) ? 3'd0 : cnt_reg + 3'd1;
          if (cnt_reg < 3'd4)  ord_addr_reg  <= ord_next;
          if (cnt_reg == 3'd5) dist_addr_reg <= {c0, c1};
        end
        RD_DIST: begin
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg < 3'd5) dist_addr_reg <= edge_next;
          // Counts 1..3 return the removed edges, 4..6 the inserted ones.
          if (cnt_reg >= 3'd1 && cnt_reg <= 3'd3) delta_reg <= delta_reg - dist_ext;
          else if (cnt_reg >= 3'd4)               delta_reg <= delta_reg + dist_ext;
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

  assign ord_addr  = ord_addr_reg;
  assign dist_addr = dist_addr_reg;
  assign opt_o     = opt_reg;
  assign delta     = delta_reg;

endmodule

// File: tb/tb_or_delta.sv
// Directed bench for or_delta: 8-city tour, d(a,b)=|a-b|, identity ordering unless reloaded.
module tb_or_delta;
  import replica_pkg::*;

  localparam int DIST_W = 16;
  localparam int CW     = 3;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      run_i = 1'b0;
  opt_t                      opt_in = '0;
  logic [CW-1:0]             ord_addr;
  logic [CW-1:0]             ord_data = '0;
  logic [2*CW-1:0]           dist_addr;
  logic [DIST_W-1:0]         dist_data = '0;
  logic                      run_o;
  opt_t                      opt_o;
  logic signed [DIST_W+2:0]  delta;
  logic                      busy;

  logic [CW-1:0] ord_mem [8];
  int            n_checks = 0;
  int            n_pass = 0;
  int            run_cyc, run_cnt, addr_chg;
  logic [CW-1:0] ord_log [5];
  logic          busy_log [32];
  opt_t          sent;

  or_delta #(.DIST_W(DIST_W), .CITY_NUM(8), .CITY_W(CW)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .opt_i(opt_in),
    .ord_addr(ord_addr), .ord_data(ord_data),
    .dist_addr(dist_addr), .dist_data(dist_data),
    .run_o(run_o), .opt_o(opt_o), .delta(delta), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ord_data  <= ord_mem[ord_addr];
    dist_data <= (dist_addr[5:3] > dist_addr[2:0]) ? DIST_W'(dist_addr[5:3] - dist_addr[2:0])
                                                   : DIST_W'(dist_addr[2:0] - dist_addr[5:3]);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Issues one command in cycle 0 and watches a 30-cycle window.
  task automatic do_cmd(input com_t com, input logic [CW-1:0] k, input logic [CW-1:0] l,
                        input int extra_at, input int reset_at);
    logic [CW-1:0]   oa0;
    logic [2*CW-1:0] da0;
    @(negedge clk);
    sent = '0;
    sent.com = com;
    sent.base_id = 4'(k + l);
    sent.K = k;
    sent.L = l;
    sent.r_metropolis = {8'hA5, 5'd0, k};
    opt_in = sent;
    run_i = 1'b1;
    oa0 = ord_addr;
    da0 = dist_addr;
    run_cyc = -1;
    run_cnt = 0;
    addr_chg = 0;
    for (int cyc = 1; cyc < 31; cyc++) begin
      @(negedge clk);
      if (cyc <= 5) ord_log[cyc-1] = ord_addr;
      busy_log[cyc] = busy;
      if (ord_addr !== oa0 || dist_addr !== da0) addr_chg++;
      if (run_o) begin
        run_cnt++;
        if (run_cyc < 0) run_cyc = cyc;
      end
      run_i = (cyc == extra_at);
      reset = (cyc == reset_at);
    end
    run_i = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ord_mem[i] = CW'(i);
    repeat (3) @(negedge clk);
    check("reset_run_o", run_o, 0);
    check("reset_busy", busy, 0);
    check("reset_delta", delta, 0);
    check("reset_opt_o", opt_o, 0);
    reset = 1'b0;

    do_cmd(OR1, 3'd3, 3'd5, 0, 0);
    $display("OR1 K=3 L=5: run_cyc=%0d delta=%0d", run_cyc, delta);
    check("or1_run_cycle", run_cyc, 14);
    check("or1_run_count", run_cnt, 1);
    check("or1_delta", delta, 4);
    check("or1_opt_o", opt_o, sent);
    check("or1_busy_c1", busy_log[1], 1);
    check("or1_busy_c14", busy_log[14], 1);
    check("or1_busy_c15", busy_log[15], 0);
    check("or1_ord_p0", ord_log[0], 2);
    check("or1_ord_p4", ord_log[4], 6);

    do_cmd(OR1, 3'd7, 3'd0, 0, 0);
    $display("OR1 K=7 L=0: run_cyc=%0d delta=%0d", run_cyc, delta);
    check("wrap_ord_p0", ord_log[0], 6);
    check("wrap_ord_p1", ord_log[1], 7);
    check("wrap_ord_p2", ord_log[2], 0);
    check("wrap_ord_p3", ord_log[3], 0);
    check("wrap_ord_p4", ord_log[4], 1);
    check("wrap_delta", delta, 10);

    do_cmd(THR, 3'd2, 3'd6, 0, 0);
    $display("THR: run_cyc=%0d delta=%0d", run_cyc, delta);
    check("thr_run_cycle", run_cyc, 1);
    check("thr_run_count", run_cnt, 1);
    check("thr_delta", delta, 0);
    check("thr_no_reads", addr_chg, 0);
    check("thr_busy_c1", busy_log[1], 1);
    check("thr_busy_c2", busy_log[2], 0);
    check("thr_opt_o", opt_o, sent);

    do_cmd(OR1, 3'd3, 3'd5, 5, 0);
    $display("OR1 with run_i at cycle 5: run_cnt=%0d delta=%0d", run_cnt, delta);
    check("busy_ignore_count", run_cnt, 1);
    check("busy_ignore_cycle", run_cyc, 14);
    check("busy_ignore_delta", delta, 4);

    do_cmd(OR1, 3'd4, 3'd1, 0, 9);
    $display("OR1 aborted by reset at cycle 9: run_cnt=%0d delta=%0d", run_cnt, delta);
    check("abort_run_count", run_cnt, 0);
    check("abort_busy_c10", busy_log[10], 0);
    check("abort_delta", delta, 0);
    check("abort_opt_com", opt_o.com, THR);
    do_cmd(OR1, 3'd3, 3'd5, 0, 0);
    $display("OR1 K=3 L=5 after abort: run_cyc=%0d delta=%0d", run_cyc, delta);
    check("after_abort_cycle", run_cyc, 14);
    check("after_abort_delta", delta, 4);

    ord_mem[1] = 3'd2;
    ord_mem[2] = 3'd1;
    do_cmd(OR1, 3'd1, 3'd2, 0, 0);
    $display("OR1 K=1 L=2 swapped tour: run_cyc=%0d delta=%0d", run_cyc, delta);
    check("neg_delta", delta, -2);
    check("neg_sign_bit", delta[DIST_W+2], 1);
    check("neg_run_count", run_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/or_delta.md
# or_delta

Consumer of the or-opt command stream produced by the random-move generator. On each command it fetches the five affected tour positions from the replica's ordering RAM, looks up the six affected edge lengths in the distance RAM, and returns the signed tour-length change of moving the city at position K to just after position L. It sits between the move generator and the metropolis/exchange stage, and forwards the command alongside the result.

## Interface
Parameters:
- `DIST_W`, 16: width of one distance word (unsigned).
- `CITY_NUM`, `city_num` from `replica_pkg`: tour length; positions are 0..CITY_NUM-1.
- `CITY_W`, `$clog2(CITY_NUM)`: width of a position or city id.

Ports:
- `clk` in 1: clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `run_i` in 1: one-cycle command strobe. `opt_i` is valid in this cycle.
- `opt_i` in `opt_t`: command. Uses `com`, `base_id`, `K`, `L` and `r_metropolis`.
- `ord_addr` out `CITY_W`: ordering RAM read address (tour position).
- `ord_data` in `CITY_W`: city id. Valid 1 cycle after `ord_addr`.
- `dist_addr` out `2*CITY_W`: distance RAM read address `{city_a, city_b}`.
- `dist_data` in `DIST_W`: distance. Valid 1 cycle after `dist_addr`.
- `run_o` out 1: one-cycle result strobe.
- `opt_o` out `opt_t`: registered copy of the accepted `opt_i`.
- `delta` out `DIST_W+3` signed: new length minus old length.
- `busy` out 1: high from the cycle after an accepted `run_i` through the `run_o` cycle.

## Operation
- States: `IDLE`, `RD_ORD`, `RD_DIST`, `DONE`.
- `IDLE`, `run_i`=1, `opt_i.com`=`THR`:
  - latch `opt_o`, set `delta`=0, go to `DONE`.
  - No memory reads.
- `IDLE`, `run_i`=1, `opt_i.com`=`OR1`:
  - latch `opt_o`, clear the accumulator, go to `RD_ORD`.
- `RD_ORD`: 5 reads, one per cycle, of positions p0=K-1, p1=K, p2=K+1, p3=L, p4=L+1.
  - All positions are mod `CITY_NUM`: K+1 or L+1 equal to `CITY_NUM` wraps to 0.
  - Captured city ids are c0..c4.
- `RD_DIST`: 6 reads, one per cycle, in this order:
  - old edges: (c0,c1), (c1,c2), (c3,c4);
  - new edges: (c0,c2), (c3,c1), (c1,c4).
  - Each returned old distance is subtracted from the accumulator; each new one is added.
  - Distances are zero-extended to `DIST_W+3` before the add/subtract. No saturation is needed: the range is ±3·(2^DIST_W−1).
- `DONE`: `run_o`=1 for exactly one cycle, then go to `IDLE`.
  - `delta` and `opt_o` hold until the next accepted command.
- The block does not validate K/L. The generator guarantees 1≤K≤CITY_NUM-1, L≠K and L≠K-1; behaviour outside that range is unspecified but must not hang the FSM.
- `run_i` while `busy`=1 is ignored: no state change, no later `run_o` for it.
- `ord_addr` and `dist_addr` are registered. Their value outside the read cycles is don't-care; the RAMs have no enable.

## Timing
- Cycle 0 is the `run_i` sample cycle.
- OR1 command:
  - `ord_addr` = p0..p4 in cycles 1..5; `ord_data` is captured in cycles 2..6.
  - `dist_addr` = edges 1..6 in cycles 7..12; `dist_data` is accumulated in cycles 8..13.
  - `run_o`=1 and `delta` is final in cycle 14.
  - `busy`=1 in cycles 1..14.
- THR command: `run_o`=1 in cycle 1, with `delta`=0 and `busy`=1 in cycle 1 only.
- Earliest next accepted `run_i` is the cycle after `run_o` (cycle 15 for OR1, cycle 2 for THR).
- Reset values: `run_o`=0, `busy`=0, `delta`=0, `opt_o.com`=`THR`, other `opt_o` fields 0, state `IDLE`.
- Reset asserted mid-operation aborts the command: the state and all outputs above return to reset values the next cycle, and no `run_o` is issued for the aborted command.

## Test plan
Bench setup: `CITY_NUM`=8; distance model d(a,b)=|a−b|; ordering RAM holds the identity tour unless stated otherwise.
- OR1 with K=3, L=5 -> `run_o` exactly in cycle 14; `delta`=+4 (old 1+1+1, new 2+2+3); `opt_o` equals the input.
- OR1 with K=7, L=0 (K+1 wraps) -> reads positions 6,7,0,0,1; `delta`=+10 (old 9, new 19).
- Ordering [0,2,1,3,4,5,6,7], OR1 with K=1, L=2 -> `delta`=−2 (old 5, new 3); the sign bit is set.
- THR command -> `run_o` in cycle 1 with `delta`=0; no `ord_addr`/`dist_addr` activity. A second `run_i` at cycle 5 of an OR1 command is ignored: exactly one `run_o`.
- `reset` pulsed in cycle 9 of an OR1 command -> `busy`=0, `run_o` never rises; a following K=3, L=5 command gives `delta`=+4 again.
